trace_capture: RTL
==================

TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameter DEPTH, default 16: number of trace records; power of two, at least 4.
REQ-002 Parameter PRE_TRIG, default 4: records kept before the trigger; 1 <= PRE_TRIG < DEPTH.
REQ-003 clk  in  1  single clock; every register updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 arm  in  1  one-cycle request to start a capture.
REQ-006 abort  in  1  one-cycle request to cancel the capture and return to IDLE.
REQ-007 trig_mode  in  2  trigger select: 0 immediate, 1 PC match, 2 MemWrite, 3 flag match.
REQ-008 trig_pc  in  32  PC compare value for mode 1.
REQ-009 trig_flags / trig_mask  in  4 / 4  NZCV compare value and mask for mode 3.
REQ-010 PC, Instr, ALUResult  in  32 each  processor observation inputs.
REQ-011 N, Z, C, V, PCSrc, MemWrite, RegWrite  in  1 each  processor observation inputs.
REQ-012 rd_en  in  1  readback request.
REQ-013 rd_addr  in  log2(DEPTH)  logical record index; 0 is the oldest record.
REQ-014 rd_data  out  103  record {N,Z,C,V,PCSrc,MemWrite,RegWrite,ALUResult,Instr,PC}, with PC in the LSBs.
REQ-015 rd_valid  out  1  rd_data is valid in this cycle.
REQ-016 state  out  2  encoding: IDLE=0, PRE=1, POST=2, DONE=3.
REQ-017 triggered  out  1  the trigger has fired during the current capture.
REQ-018 done  out  1  high while state is DONE.

Function
REQ-019 Record: one sample per clk in PRE and POST; the record is the REQ-014 concatenation of that cycle's inputs, written at wr_ptr; wr_ptr then increments modulo DEPTH.
REQ-020 IDLE: nothing is written. An arm pulse moves the block to PRE and clears wr_ptr, pre_cnt, post_cnt and triggered.
REQ-021 PRE: the block writes every cycle and pre_cnt saturates at PRE_TRIG. Older records are overwritten circularly.
REQ-022 Trigger qualification: the trigger condition is evaluated only when pre_cnt equals PRE_TRIG at the start of the cycle. A condition true before that point is ignored.
REQ-023 Trigger conditions: mode 0 is always true; mode 1 is PC == trig_pc; mode 2 is MemWrite == 1; mode 3 is ({N,Z,C,V} & trig_mask) == (trig_flags & trig_mask).
REQ-024 On a qualified trigger, the current sample is written as the trigger record, triggered is set, post_cnt becomes 1, and the next state is POST.
REQ-025 POST: the block writes every cycle and post_cnt increments. The sample that makes post_cnt equal DEPTH-PRE_TRIG is written, and the next state is DONE.
REQ-026 Record counts: after DONE, the buffer holds exactly PRE_TRIG pre-trigger records, the trigger record, and DEPTH-PRE_TRIG-1 post-trigger records. The oldest record is at physical wr_ptr.
REQ-027 DONE: no writes occur and wr_ptr is frozen. An arm pulse restarts the capture as in REQ-020.
REQ-028 An arm pulse while in PRE or POST is ignored.
REQ-029 abort: from any state, abort moves the block to IDLE next cycle and clears triggered and done. Buffer contents are kept.
REQ-030 Simultaneous arm and abort: abort wins.
REQ-031 Readback: rd_en in DONE gives rd_data = mem[(wr_ptr + rd_addr) mod DEPTH] and rd_valid = 1 on the following cycle. Back-to-back reads sustain one record per cycle.
REQ-032 rd_en outside DONE: rd_valid = 0 next cycle and rd_data holds its last value.
REQ-033 Abort mid-read: if abort coincides with rd_en, rd_valid is 0 next cycle.
REQ-034 Logical index PRE_TRIG always addresses the trigger record.

Reset
REQ-035 When reset is high at a clk edge: state = IDLE, and wr_ptr, pre_cnt, post_cnt, triggered, done, rd_valid and rd_data are all 0.
REQ-036 Memory contents are not reset.
REQ-037 Reset overrides arm, abort and rd_en in the same cycle.
REQ-038 Reset asserted mid-capture discards the capture.

Verification (DEPTH=16, PRE_TRIG=4)
REQ-039 Mode 0: arm with PC incrementing by 4 from 0x0 each cycle. Required: trigger at the 5th sample (PC=0x10); DONE after 16 samples; rd_addr 0..15 returns PC 0x0..0x3C; rd_addr 4 returns 0x10.
REQ-040 Mode 1: trig_pc=0x08 and the PC stream starts at 0x0. Required: PC=0x08 occurs with pre_cnt=2 and is ignored; the PC stream wraps and the trigger fires on the next PC=0x08 with pre_cnt=4; rd_addr 4 returns PC=0x08.
REQ-041 Mode 3: trig_mask=0100, trig_flags=0100, and Z rises at the 9th sample. Required: triggered=1 after that sample; record 4 has Z=1; records 0..3 have Z=0.
REQ-042 Abort in POST: abort after 2 post samples. Required: state=0 and done=0 next cycle; rd_en then gives rd_valid=0.
REQ-043 arm and abort in the same cycle while in IDLE: state remains 0. Reset asserted in POST: all outputs 0 next cycle.
REQ-044 Readback: rd_en held for 16 cycles in DONE. Required: rd_valid high for 16 consecutive cycles starting one cycle after the first rd_en, with data in logical order.

Source files
------------

// File: rtl/trace_capture_if.sv
// Processor observation bus sampled by the trace capture block.
// Latency: none, plain signal bundle.
// Backpressure: none, the observed core never stalls for tracing.
interface trace_capture_if;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic [31:0] ALUResult;
  logic        N;
  logic        Z;
  logic        C;
  logic        V;
  logic        PCSrc;
  logic        MemWrite;
  logic        RegWrite;

  modport master (
    output PC, Instr, ALUResult, N, Z, C, V, PCSrc, MemWrite, RegWrite
  );

  modport slave (
    input PC, Instr, ALUResult, N, Z, C, V, PCSrc, MemWrite, RegWrite
  );
endinterface

// File: rtl/trace_capture.sv
// Pre/post-trigger trace buffer for a processor observation bus, with indexed readback.
// Latency: one sample written per cycle in PRE/POST; readback data valid one cycle after rd_en.
// Backpressure: none; rd_en is honoured only in DONE, otherwise rd_valid stays low.
module trace_capture #(
  parameter int DEPTH    = 16,
  parameter int PRE_TRIG = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [1:0]               trig_mode,
  input  logic [31:0]              trig_pc,
  input  logic [3:0]               trig_flags,
  input  logic [3:0]               trig_mask,
  trace_capture_if.slave           obs,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [102:0]             rd_data,
  output logic                     rd_valid,
  output logic [1:0]               state,
  output logic                     triggered,
  output logic                     done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] PRE_TRIG_C = CW'(PRE_TRIG);
  localparam logic [CW-1:0] POST_LEN_C = CW'(DEPTH - PRE_TRIG);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   pre_cnt_q, pre_cnt_d;
  logic [CW-1:0]   post_cnt_q, post_cnt_d;
  logic            triggered_q, triggered_d;
  logic            rd_valid_q, rd_valid_d;
  logic [102:0]    rd_data_q, rd_data_d;

  logic [102:0]    mem [DEPTH];
  logic            wr_en;
  logic [102:0]    sample;
  logic            trig_hit;
  logic [AW-1:0]   rd_idx;

  // Current observation packed as a record, PC in the LSBs.
  assign sample = {obs.N, obs.Z, obs.C, obs.V, obs.PCSrc, obs.MemWrite, obs.RegWrite,
                   obs.ALUResult, obs.Instr, obs.PC};

  // Logical index 0 is the oldest record, which sits at the write pointer once frozen.
  assign rd_idx = wr_ptr_q + rd_addr;

  // Raw trigger condition for the selected mode; qualification happens in the FSM.
  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode)
      2'd0:    trig_hit = 1'b1;
      2'd1:    trig_hit = (obs.PC == trig_pc);
      2'd2:    trig_hit = obs.MemWrite;
      default: trig_hit = (({obs.N, obs.Z, obs.C, obs.V} & trig_mask) == (trig_flags & trig_mask));
    endcase
  end

  // Capture FSM next-state, pointer/counter updates and readback request handling.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    triggered_d = triggered_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    wr_en       = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_d     = ST_PRE;
          wr_ptr_d    = '0;
          pre_cnt_d   = '0;
          post_cnt_d  = '0;
          triggered_d = 1'b0;
        end
      end
      ST_PRE: begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        // Only a full pre-trigger window may accept a trigger.
        if (pre_cnt_q == PRE_TRIG_C && trig_hit) begin
          triggered_d = 1'b1;
          post_cnt_d  = CW'(1);
          state_d     = (POST_LEN_C == CW'(1)) ? ST_DONE : ST_POST;
        end else if (pre_cnt_q != PRE_TRIG_C) begin
          pre_cnt_d = pre_cnt_q + 1'b1;
        end
      end
      default: begin
        wr_en      = 1'b1;
        wr_ptr_d   = wr_ptr_q + 1'b1;
        post_cnt_d = post_cnt_q + 1'b1;
        if (post_cnt_d == POST_LEN_C) begin
          state_d = ST_DONE;
        end
      end
    endcase

    if (state_q == ST_DONE && rd_en) begin
      rd_valid_d = 1'b1;
      rd_data_d  = mem[rd_idx];
    end

    // Abort beats everything else in the cycle, including a pending read.
    if (abort) begin
      state_d     = ST_IDLE;
      triggered_d = 1'b0;
      wr_en       = 1'b0;
      wr_ptr_d    = wr_ptr_q;
      pre_cnt_d   = pre_cnt_q;
      post_cnt_d  = post_cnt_q;
      rd_valid_d  = 1'b0;
      rd_data_d   = rd_data_q;
    end
  end

  // Control and readback registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      triggered_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      triggered_q <= triggered_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Trace storage; contents survive reset and abort.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_ptr_q] <= sample;
    end
  end

  assign state     = state_q;
  assign triggered = triggered_q;
  assign done      = (state_q == ST_DONE);
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
endmodule
